uart_tx_arbiter: RTL and testbench

Round-robin arbiter and frame sequencer that shares the single `uart_transmitter` between `NUM_REQ` byte requesters. It accepts a byte from one requester at a time and drives `tx_en` / `tx_data` into the transmitter. Frame boundaries are timed by counting `tx_clk_en` baud ticks from `uart_clock_generator`, because the transmitter has no busy output. It sits between the application-side byte sources and the `uart` datapath in the same `sys_clk` domain.

---
 rtl/uart_tx_arbiter.sv | 154 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between NUM_REQ byte sources.
// Frame and inter-frame gap lengths are timed by counting tx_clk_en baud ticks.
module uart_tx_arbiter #(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned FRAME_TICKS = 10,
   parameter int unsigned GAP_TICKS   = 1
) (
   input  logic                       sys_clk,
   input  logic                       rst,
   input  logic                       tx_clk_en,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [8*NUM_REQ-1:0]       req_data,
   output logic [NUM_REQ-1:0]         ack,
   output logic                       tx_en,
   output logic [7:0]                 tx_data,
   output logic                       busy,
   output logic [$clog2(NUM_REQ)-1:0] grant_id
);

   localparam int unsigned IdW      = $clog2(NUM_REQ);
   localparam int unsigned MaxTicks = (FRAME_TICKS > GAP_TICKS) ? FRAME_TICKS : GAP_TICKS;
   localparam int unsigned CntW     = $clog2(MaxTicks + 1);

   localparam logic [CntW-1:0]    FrameTicks = CntW'(FRAME_TICKS);
   localparam logic [CntW-1:0]    GapTicks   = CntW'(GAP_TICKS);
   localparam logic [IdW-1:0]     LastInit   = IdW'(NUM_REQ - 1);
   localparam logic [NUM_REQ-1:0] OneHot0    = {{(NUM_REQ-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

   state_e               state_q, state_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic [IdW-1:0]       last_q, last_d;
   logic [IdW-1:0]       grant_q, grant_d;
   logic [NUM_REQ-1:0]   ack_q, ack_d;
   logic                 tx_en_q, tx_en_d;
   logic [7:0]           tx_data_q, tx_data_d;
   logic                 busy_q, busy_d;

   logic [7:0]           req_byte [NUM_REQ];
   logic                 win_found;
   logic [IdW-1:0]       win_id;
   logic [CntW-1:0]      cnt_inc;
   int unsigned          scan_idx;

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         req_byte[i] = req_data[8*i +: 8];
      end
   end

   // Scan from last+1 upward with wrap; the first set request wins.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      scan_idx  = 0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         scan_idx = int'(last_q) + k;
         if (scan_idx >= NUM_REQ) begin
            scan_idx = scan_idx - NUM_REQ;
         end
         if (!win_found && req[IdW'(scan_idx)]) begin
            win_found = 1'b1;
            win_id    = IdW'(scan_idx);
         end
      end
   end

   assign cnt_inc = cnt_q + 1'b1;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      last_d    = last_q;
      grant_d   = grant_q;
      ack_d     = '0;
      tx_en_d   = tx_en_q;
      tx_data_d = tx_data_q;
      busy_d    = busy_q;
      unique case (state_q)
         StIdle: begin
            if (win_found) begin
               tx_data_d = req_byte[win_id];
               tx_en_d   = 1'b1;
               busy_d    = 1'b1;
               ack_d     = OneHot0 << win_id;
               grant_d   = win_id;
               last_d    = win_id;
               cnt_d     = '0;
               state_d   = StSend;
            end
         end
         StSend: begin
            if (tx_clk_en) begin
               if (cnt_inc == FrameTicks) begin
                  tx_en_d = 1'b0;
                  cnt_d   = '0;
                  if (GAP_TICKS > 0) begin
                     state_d = StGap;
                  end else begin
                     state_d = StIdle;
                     busy_d  = 1'b0;
                  end
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         StGap: begin
            if (tx_clk_en) begin
               if (cnt_inc == GapTicks) begin
                  cnt_d   = '0;
                  state_d = StIdle;
                  busy_d  = 1'b0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         last_q    <= LastInit;
         grant_q   <= '0;
         ack_q     <= '0;
         tx_en_q   <= 1'b0;
         tx_data_q <= 8'h00;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         last_q    <= last_d;
         grant_q   <= grant_d;
         ack_q     <= ack_d;
         tx_en_q   <= tx_en_d;
         tx_data_q <= tx_data_d;
         busy_q    <= busy_d;
      end
   end

   assign ack      = ack_q;
   assign tx_en    = tx_en_q;
   assign tx_data  = tx_data_q;
   assign busy     = busy_q;
   assign grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: one instance with a one-tick gap, one with no gap.
// Expected grants are queued when requests are raised and popped on each observed ack.
module tb_uart_tx_arbiter;

   localparam int Frame = 10;
   localparam int Gap   = 1;

   logic        sys_clk = 1'b0;
   logic        rst = 1'b1;
   logic        tx_clk_en = 1'b0;
   logic [3:0]  req = '0, req0 = '0;
   logic [3:0]  hold = '0, hold0 = '0;
   logic [31:0] req_data = '0, req_data0 = '0;

   logic [3:0]  ack, ack0;
   logic        tx_en, tx_en0, busy, busy0;
   logic [7:0]  tx_data, tx_data0;
   logic [1:0]  grant_id, grant_id0;

   uart_tx_arbiter #(.NUM_REQ(4), .FRAME_TICKS(Frame), .GAP_TICKS(Gap)) dut (
      .sys_clk(sys_clk), .rst(rst), .tx_clk_en(tx_clk_en), .req(req), .req_data(req_data),
      .ack(ack), .tx_en(tx_en), .tx_data(tx_data), .busy(busy), .grant_id(grant_id)
   );

   uart_tx_arbiter #(.NUM_REQ(4), .FRAME_TICKS(Frame), .GAP_TICKS(0)) dut0 (
      .sys_clk(sys_clk), .rst(rst), .tx_clk_en(tx_clk_en), .req(req0), .req_data(req_data0),
      .ack(ack0), .tx_en(tx_en0), .tx_data(tx_data0), .busy(busy0), .grant_id(grant_id0)
   );

   always #5 sys_clk = ~sys_clk;

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   typedef struct packed {
      logic [1:0] id;
      logic [7:0] data;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   task automatic expect_grant(input logic [1:0] id, input logic [7:0] d);
      sb.push_back({id, d});
   endtask

   // Stimulus driver: baud tick every 3 cycles, requesters drop req on their ack unless held.
   int   phase = 0;
   logic tick_on = 1'b0;
   logic tick_force = 1'b0;

   task automatic step();
      @(negedge sys_clk);
      phase = (phase == 2) ? 0 : phase + 1;
      tx_clk_en = tick_force | (tick_on && phase == 0);
      for (int i = 0; i < 4; i++) begin
         if (ack[i] && !hold[i]) req[i] = 1'b0;
         if (ack0[i] && !hold0[i]) req0[i] = 1'b0;
      end
      #1;
   endtask

   // Monitor for dut: pops the scoreboard on ack, measures counted frame and gap ticks.
   logic       prev_en = 1'b0, prev_busy = 1'b0;
   logic [3:0] prev_ack = '0;
   logic [7:0] frame_data = '0;
   int         fcnt = 0, gcnt = 0, ack_cnt = 0;

   initial begin
      forever begin
         @(posedge sys_clk);
         #1;
         if (rst) begin
            prev_en = 1'b0; prev_busy = 1'b0; prev_ack = '0; fcnt = 0; gcnt = 0;
         end else begin
            if (prev_en && tx_clk_en) fcnt++;
            if (prev_busy && !prev_en && tx_clk_en) gcnt++;
            if (ack != 4'b0) begin
               check("ack_pulse", 32'(prev_ack), 0);
               if (sb.size() == 0) begin
                  check("sb_unexpected_ack", 32'(ack), 0);
               end else begin
                  mon_e = sb.pop_front();
                  check("ack_onehot", 32'(ack), 32'(4'b0001 << mon_e.id));
                  check("grant_id", 32'(grant_id), 32'(mon_e.id));
                  check("tx_data", 32'(tx_data), 32'(mon_e.data));
                  check("tx_en_at_grant", 32'(tx_en), 1);
                  check("busy_at_grant", 32'(busy), 1);
               end
               ack_cnt++;
               fcnt = 0;
               gcnt = 0;
               frame_data = tx_data;
            end else if (tx_en) begin
               check("tx_data_hold", 32'(tx_data), 32'(frame_data));
            end
            if (prev_en && !tx_en) check("frame_ticks", fcnt, Frame);
            if (prev_busy && !busy) begin
               check("gap_ticks", gcnt, Gap);
               check("busy_fall_tx_en", 32'(tx_en), 0);
            end
            prev_en = tx_en; prev_busy = busy; prev_ack = ack;
         end
      end
   end

   task automatic wait_acks(input int n, input string tag);
      int b = 3000;
      while (ack_cnt < n && b > 0) begin
         step();
         b--;
      end
      check(tag, 32'(ack_cnt >= n), 1);
   endtask

   task automatic wait_idle(input string tag);
      int b = 3000;
      step();
      while ((busy || busy0) && b > 0) begin
         step();
         b--;
      end
      check(tag, 32'(busy | busy0), 0);
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   int base;
   int b;

   initial begin
      rst = 1'b1;
      step();
      step();
      check("rst_ack", 32'(ack), 0);
      check("rst_tx_en", 32'(tx_en), 0);
      check("rst_tx_data", 32'(tx_data), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_grant_id", 32'(grant_id), 0);
      rst = 1'b0;
      tick_on = 1'b1;
      step();
      step();

      // Single requester
      req_data[23:16] = 8'hA5;
      expect_grant(2'd2, 8'hA5);
      req[2] = 1'b1;
      step();
      check("t1_ack_latency", 32'(ack), 32'h4);
      check("t1_grant_id", 32'(grant_id), 2);
      step();
      check("t1_ack_one_cycle", 32'(ack), 0);
      wait_idle("t1_idle");

      // Round robin with all requests held from reset
      rst = 1'b1;
      req_data = 32'h13121110;
      hold = 4'hf;
      req = 4'hf;
      for (int i = 0; i < 5; i++) expect_grant(2'(i % 4), 8'(16 + i % 4));
      base = ack_cnt;
      step();
      rst = 1'b0;
      wait_acks(base + 5, "t2_acks");
      req = '0;
      hold = '0;
      wait_idle("t2_idle");

      // Fairness: req[3] raised during req[1]'s frame wins next
      base = ack_cnt;
      req_data[15:8] = 8'h21;
      req_data[31:24] = 8'h33;
      expect_grant(2'd1, 8'h21);
      expect_grant(2'd3, 8'h33);
      expect_grant(2'd1, 8'h21);
      hold[1] = 1'b1;
      req[1] = 1'b1;
      wait_acks(base + 1, "t3_first");
      repeat (5) step();
      req[3] = 1'b1;
      wait_acks(base + 2, "t3_second");
      check("t3_grant_3", 32'(grant_id), 3);
      repeat (4) step();
      req_data[31:24] = 8'h44;
      repeat (8) step();
      check("t3_data_stable", 32'(tx_data), 32'h33);
      wait_acks(base + 3, "t3_third");
      req[1] = 1'b0;
      hold[1] = 1'b0;
      wait_idle("t3_idle");

      // Tick in the grant cycle is not counted
      base = ack_cnt;
      tick_on = 1'b0;
      tick_force = 1'b1;
      req_data[7:0] = 8'h5A;
      expect_grant(2'd0, 8'h5A);
      step();
      req[0] = 1'b1;
      step();
      tick_force = 1'b0;
      tick_on = 1'b1;
      check("t4_ack", 32'(ack), 32'h1);
      wait_idle("t4_idle");

      // Reset mid-frame
      base = ack_cnt;
      req_data[23:16] = 8'h77;
      expect_grant(2'd2, 8'h77);
      req[2] = 1'b1;
      wait_acks(base + 1, "t6_grant");
      b = 500;
      while (fcnt != 5 && b > 0) begin
         step();
         b--;
      end
      check("t6_reach_tick5", fcnt, 5);
      #1 rst = 1'b1;
      #1;
      check("t6_rst_tx_en", 32'(tx_en), 0);
      check("t6_rst_busy", 32'(busy), 0);
      check("t6_rst_ack", 32'(ack), 0);
      check("t6_rst_grant_id", 32'(grant_id), 0);
      step();
      rst = 1'b0;
      req_data[7:0] = 8'h80;
      req_data[31:24] = 8'h83;
      expect_grant(2'd0, 8'h80);
      expect_grant(2'd3, 8'h83);
      req = 4'b1001;
      wait_acks(base + 3, "t6_after_rst");
      wait_idle("t6_idle");

      // GAP_TICKS=0: single low cycle between back-to-back frames
      req_data0 = 32'h00006261;
      hold0 = 4'b0011;
      req0 = 4'b0011;
      b = 500;
      while (ack0 == 4'b0 && b > 0) begin
         step();
         b--;
      end
      check("t5_first_ack", 32'(ack0), 32'h1);
      check("t5_first_data", 32'(tx_data0), 32'h61);
      b = 500;
      while (tx_en0 && b > 0) begin
         step();
         b--;
      end
      check("t5_low_en", 32'(tx_en0), 0);
      check("t5_low_ack", 32'(ack0), 0);
      step();
      check("t5_second_en", 32'(tx_en0), 1);
      check("t5_second_ack", 32'(ack0), 32'h2);
      check("t5_second_data", 32'(tx_data0), 32'h62);
      req0 = '0;
      hold0 = '0;
      wait_idle("t5_idle");

      check("sb_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
